i_type_exec_unit: RTL and testbench

Parametrised multi-cycle executor for MIPS I-type ALU instructions (ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI). Owns the architectural register file, the immediate extender and the ALU control decode. Accepts one instruction per start/ready handshake, runs it through a three-state FSM and writes the result back to `rt`. Sits between the instruction decoder and the register/ALU datapath; the next generation of the single-cycle I-type datapath, adding handshaking, overflow trapping, illegal-opcode detection and width/depth parameters.

---
 rtl/i_type_exec_unit.sv | 210 +++++++++++++++++++++
 tb/tb_i_type_exec_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_type_exec_unit.sv
// -----------------------------------------------------------------------------
// i_type_exec_unit
//
// Multi-cycle executor for MIPS I-type ALU instructions
// (ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI/LUI). Holds the architectural register
// file, extends the immediate, decodes the opcode and writes the result back
// to rt. One instruction is accepted per start/ready handshake and walks
// through IDLE -> EXEC -> WB.
//
// Parameters
//   DATA_W     datapath / register width (32..64)
//   REG_COUNT  number of registers (power of two, 2..32)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      instruction valid, taken only while ready=1
//   opcode     MIPS primary opcode
//   rs, rt     source / destination register indices
//   imm        16-bit immediate
//   ready      unit idle, can accept
//   done       one-cycle pulse while in WB
//   result     ALU result, held until the next WB
//   datars     rs operand of the current/last instruction
//   datart     old rt contents read in EXEC
//   overflow   signed overflow of ADDI (valid with done)
//   zero       result == 0 (valid with done)
//   illegal    unsupported opcode (valid with done)
//   dbg_addr   debug read address
//   dbg_data   combinational register-file read data
// -----------------------------------------------------------------------------
module i_type_exec_unit #(
    parameter int DATA_W    = 32,
    parameter int REG_COUNT = 32,
    localparam int AW       = $clog2(REG_COUNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [5:0]        opcode,
    input  logic [AW-1:0]     rs,
    input  logic [AW-1:0]     rt,
    input  logic [15:0]       imm,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] datars,
    output logic [DATA_W-1:0] datart,
    output logic              overflow,
    output logic              zero,
    output logic              illegal,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t              r_state;
    logic [5:0]          r_op;
    logic [AW-1:0]       r_rs;
    logic [AW-1:0]       r_rt;
    logic [15:0]         r_imm;
    logic                r_ready;
    logic                r_done;
    logic [DATA_W-1:0]   r_result;
    logic [DATA_W-1:0]   r_datars;
    logic [DATA_W-1:0]   r_datart;
    logic                r_ovf;
    logic                r_zero;
    logic                r_ill;
    logic [DATA_W-1:0]   r_regs [REG_COUNT];

    logic signed [15:0]       w_imm_s;
    logic signed [31:0]       w_lui32;
    logic signed [DATA_W-1:0] w_simm;
    logic        [DATA_W-1:0] w_zimm;
    logic signed [DATA_W-1:0] w_lui;
    logic        [DATA_W-1:0] w_a;
    logic        [DATA_W-1:0] w_b;
    logic        [DATA_W-1:0] w_sum;
    logic                     w_add_ovf;
    logic                     w_lt_s;
    logic                     w_lt_u;
    logic        [DATA_W-1:0] w_res;
    logic                     w_ovf;
    logic                     w_ill;

    // Register 0 is hard-wired to zero on every read port.
    assign w_a      = (r_rs == '0)     ? '0 : r_regs[r_rs];
    assign w_b      = (r_rt == '0)     ? '0 : r_regs[r_rt];
    assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

    // Size casts of signed values sign-extend, which avoids zero-width
    // replications when DATA_W is exactly 32.
    assign w_imm_s = r_imm;
    assign w_lui32 = {r_imm, 16'h0000};
    assign w_simm  = DATA_W'(w_imm_s);
    assign w_zimm  = DATA_W'(r_imm);
    assign w_lui   = DATA_W'(w_lui32);

    assign w_sum     = w_a + w_simm;
    // Two operands of equal sign producing a sum of the other sign.
    assign w_add_ovf = (w_a[DATA_W-1] == w_simm[DATA_W-1]) &&
                       (w_sum[DATA_W-1] != w_a[DATA_W-1]);
    assign w_lt_s    = $signed(w_a) < w_simm;
    assign w_lt_u    = w_a < DATA_W'(w_simm);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        w_ill = 1'b0;
        case (r_op)
            OP_ADDI: begin
                w_res = w_sum;
                w_ovf = w_add_ovf;
            end
            OP_ADDIU: w_res = w_sum;
            OP_SLTI:  w_res = {{(DATA_W-1){1'b0}}, w_lt_s};
            OP_SLTIU: w_res = {{(DATA_W-1){1'b0}}, w_lt_u};
            OP_ANDI:  w_res = w_a & w_zimm;
            OP_ORI:   w_res = w_a | w_zimm;
            OP_XORI:  w_res = w_a ^ w_zimm;
            OP_LUI:   w_res = w_lui;
            default:  w_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_imm    <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_result <= '0;
            r_datars <= '0;
            r_datart <= '0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b0;
            r_ill    <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= DATA_W'(i);
            end
        end else begin
            case (r_state)
                // IDLE: latch the instruction fields on start.
                S_IDLE: begin
                    if (start) begin
                        r_op    <= opcode;
                        r_rs    <= rs;
                        r_rt    <= rt;
                        r_imm   <= imm;
                        r_ready <= 1'b0;
                        r_state <= S_EXEC;
                    end
                end
                // EXEC: register operands, result and flags.
                S_EXEC: begin
                    r_datars <= w_a;
                    r_datart <= w_b;
                    r_result <= w_res;
                    r_ovf    <= w_ovf;
                    r_ill    <= w_ill;
                    r_zero   <= (w_res == '0);
                    r_done   <= 1'b1;
                    r_state  <= S_WB;
                end
                // WB: commit unless the target is r0, or the op trapped.
                S_WB: begin
                    if ((r_rt != '0) && !r_ovf && !r_ill) begin
                        r_regs[r_rt] <= r_result;
                    end
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready    = r_ready;
    assign done     = r_done;
    assign result   = r_result;
    assign datars   = r_datars;
    assign datart   = r_datart;
    assign overflow = r_ovf;
    assign zero     = r_zero;
    assign illegal  = r_ill;

endmodule

// File: tb/tb_i_type_exec_unit.sv
module tb_i_type_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, dbg_addr;
    logic [15:0] imm;
    logic        ready, done, overflow, zero, illegal;
    logic [31:0] result, datars, datart, dbg_data;

    logic        s64_start;
    logic [5:0]  s64_op;
    logic [4:0]  s64_rs, s64_rt, s64_dbg_addr;
    logic [15:0] s64_imm;
    logic        s64_ready, s64_done, s64_ovf, s64_zero, s64_ill;
    logic [63:0] s64_result, s64_datars, s64_datart, s64_dbg_data;

    int total = 0;
    int bad   = 0;
    logic [31:0] mregs [32];

    typedef struct packed {
        logic        timeout;
        logic        exec_ready;
        logic        exec_done;
        logic        done;
        logic        ovf;
        logic        zero;
        logic        ill;
        logic        ready_after;
        logic        done_after;
        logic [31:0] result;
        logic [31:0] datars;
        logic [31:0] datart;
        logic [31:0] dbg_wb;
        logic [31:0] dbg_after;
    } obs_t;

    i_type_exec_unit #(.DATA_W(32), .REG_COUNT(32)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .rs(rs), .rt(rt),
        .imm(imm), .ready(ready), .done(done), .result(result), .datars(datars),
        .datart(datart), .overflow(overflow), .zero(zero), .illegal(illegal),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    i_type_exec_unit #(.DATA_W(64), .REG_COUNT(32)) dut64 (
        .clk(clk), .rst(rst), .start(s64_start), .opcode(s64_op), .rs(s64_rs),
        .rt(s64_rt), .imm(s64_imm), .ready(s64_ready), .done(s64_done),
        .result(s64_result), .datars(s64_datars), .datart(s64_datart),
        .overflow(s64_ovf), .zero(s64_zero), .illegal(s64_ill),
        .dbg_addr(s64_dbg_addr), .dbg_data(s64_dbg_data)
    );

    always #5 clk = ~clk;

    // Reference semantics of one instruction on a 32-bit machine, from the
    // instruction definitions using wide integer arithmetic.
    function automatic void model_exec(input logic [5:0] op, input logic [31:0] a,
                                       input logic [15:0] im, output logic [31:0] res,
                                       output logic ovf, output logic ill);
        longint sa = longint'($signed(a));
        longint si = longint'($signed(im));
        longint s;
        logic [31:0] sx = 32'(si);
        res = 32'h0; ovf = 1'b0; ill = 1'b0;
        case (op)
            6'h08: begin s = sa + si; res = 32'(s); ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            6'h09: res = a + sx;
            6'h0A: res = (sa < si) ? 32'd1 : 32'd0;
            6'h0B: res = (a < sx) ? 32'd1 : 32'd0;
            6'h0C: res = a & {16'h0, im};
            6'h0D: res = a | {16'h0, im};
            6'h0E: res = a ^ {16'h0, im};
            6'h0F: res = {im, 16'h0};
            default: ill = 1'b1;
        endcase
    endfunction

    // Expected outcome plus architectural update of the model register file.
    task automatic model_step(input logic [5:0] op, input logic [4:0] r_s, input logic [4:0] r_t,
                              input logic [15:0] im, output logic [31:0] res, output logic ovf,
                              output logic ill, output logic [31:0] a, output logic [31:0] old_t);
        a     = mregs[r_s];
        old_t = mregs[r_t];
        model_exec(op, a, im, res, ovf, ill);
        if (r_t != 5'd0 && !ovf && !ill) mregs[r_t] = res;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'(i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; s64_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Drives one instruction and records what the DUT shows in each phase.
    task automatic issue(input logic [5:0] op, input logic [4:0] r_s, input logic [4:0] r_t,
                         input logic [15:0] im, output obs_t o);
        int n = 0;
        o = '0;
        while (!ready && n < 10) begin @(negedge clk); n++; end
        if (!ready) begin
            total++; bad++;
            $display("FAIL issue_ready_timeout: got ready=%0b want 1", ready);
            o.timeout = 1'b1;
            return;
        end
        opcode = op; rs = r_s; rt = r_t; imm = im; dbg_addr = r_t; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        o.exec_ready = ready; o.exec_done = done;
        @(posedge clk); @(negedge clk);
        o.done = done; o.result = result; o.ovf = overflow; o.zero = zero; o.ill = illegal;
        o.datars = datars; o.datart = datart; o.dbg_wb = dbg_data;
        @(posedge clk); @(negedge clk);
        o.ready_after = ready; o.done_after = done; o.dbg_after = dbg_data;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({ready, done, overflow, zero, illegal} !== 5'b10000) begin bad++;
            $display("FAIL reset_ctrl: got rdy/done/ovf/zero/ill=%b want 10000", {ready, done, overflow, zero, illegal}); end
        total++; if ({result, datars, datart} !== 96'h0) begin bad++;
            $display("FAIL reset_data: got %h/%h/%h want 0", result, datars, datart); end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); #1;
            total++; if (dbg_data !== 32'(i)) begin bad++;
                $display("FAIL reset_reg%0d: got %h want %h", i, dbg_data, 32'(i)); end
        end
    endtask

    task automatic test_addi_basic();
        obs_t o;
        logic [31:0] r, a, ot; logic v, il;
        issue(6'h08, 5'd3, 5'd5, 16'hFFFF, o);
        model_step(6'h08, 5'd3, 5'd5, 16'hFFFF, r, v, il, a, ot);
        total++; if ({o.exec_ready, o.exec_done} !== 2'b00) begin bad++;
            $display("FAIL addi_exec_phase: got ready/done=%b want 00", {o.exec_ready, o.exec_done}); end
        total++; if (o.done !== 1'b1 || o.result !== 32'd2 || o.zero !== 1'b0 || o.ovf !== 1'b0) begin bad++;
            $display("FAIL addi_wb: got done=%b res=%h zero=%b ovf=%b want 1 2 0 0", o.done, o.result, o.zero, o.ovf); end
        total++; if (o.datars !== 32'd3 || o.datart !== 32'd5) begin bad++;
            $display("FAIL addi_operands: got %h/%h want 3/5", o.datars, o.datart); end
        total++; if (o.dbg_wb !== 32'd5) begin bad++;
            $display("FAIL addi_dbg_during_wb: got %h want 5", o.dbg_wb); end
        total++; if (o.ready_after !== 1'b1 || o.done_after !== 1'b0 || o.dbg_after !== 32'd2) begin bad++;
            $display("FAIL addi_after: got ready=%b done=%b reg5=%h want 1 0 2", o.ready_after, o.done_after, o.dbg_after); end
    endtask

    task automatic test_overflow();
        obs_t o;
        logic [31:0] r, a, ot; logic v, il;
        issue(6'h0F, 5'd0, 5'd1, 16'h7FFF, o); model_step(6'h0F, 5'd0, 5'd1, 16'h7FFF, r, v, il, a, ot);
        issue(6'h0D, 5'd1, 5'd1, 16'hFFFF, o); model_step(6'h0D, 5'd1, 5'd1, 16'hFFFF, r, v, il, a, ot);
        total++; if (o.dbg_after !== 32'h7FFFFFFF) begin bad++;
            $display("FAIL ovf_preload: got %h want 7fffffff", o.dbg_after); end
        issue(6'h08, 5'd1, 5'd2, 16'h0001, o); model_step(6'h08, 5'd1, 5'd2, 16'h0001, r, v, il, a, ot);
        total++; if (o.ovf !== 1'b1 || o.done !== 1'b1 || o.ill !== 1'b0) begin bad++;
            $display("FAIL addi_overflow: got ovf=%b done=%b ill=%b want 1 1 0", o.ovf, o.done, o.ill); end
        total++; if (o.dbg_after !== 32'd2) begin bad++;
            $display("FAIL addi_ovf_nowrite: got reg2=%h want 2", o.dbg_after); end
        issue(6'h09, 5'd1, 5'd2, 16'h0001, o); model_step(6'h09, 5'd1, 5'd2, 16'h0001, r, v, il, a, ot);
        total++; if (o.ovf !== 1'b0 || o.result !== 32'h80000000 || o.dbg_after !== 32'h80000000) begin bad++;
            $display("FAIL addiu_wrap: got ovf=%b res=%h reg2=%h want 0 80000000 80000000", o.ovf, o.result, o.dbg_after); end
    endtask

    task automatic test_logic_lui();
        obs_t o;
        logic [31:0] r, a, ot; logic v, il;
        issue(6'h0D, 5'd0, 5'd4, 16'h8000, o); model_step(6'h0D, 5'd0, 5'd4, 16'h8000, r, v, il, a, ot);
        total++; if (o.result !== 32'h00008000 || o.dbg_after !== 32'h00008000) begin bad++;
            $display("FAIL ori_zext: got res=%h reg4=%h want 00008000", o.result, o.dbg_after); end
        issue(6'h0F, 5'd0, 5'd4, 16'h8001, o); model_step(6'h0F, 5'd0, 5'd4, 16'h8001, r, v, il, a, ot);
        total++; if (o.result !== 32'h80010000 || o.dbg_after !== 32'h80010000) begin bad++;
            $display("FAIL lui: got res=%h reg4=%h want 80010000", o.result, o.dbg_after); end
        issue(6'h0C, 5'd4, 5'd6, 16'hFFFF, o); model_step(6'h0C, 5'd4, 5'd6, 16'hFFFF, r, v, il, a, ot);
        total++; if (o.result !== 32'h0 || o.zero !== 1'b1) begin bad++;
            $display("FAIL andi_zero: got res=%h zero=%b want 0 1", o.result, o.zero); end
        issue(6'h0E, 5'd4, 5'd6, 16'hF00F, o); model_step(6'h0E, 5'd4, 5'd6, 16'hF00F, r, v, il, a, ot);
        total++; if (o.result !== 32'h8001F00F) begin bad++;
            $display("FAIL xori: got %h want 8001f00f", o.result); end
    endtask

    task automatic test_compare();
        obs_t o;
        logic [31:0] r, a, ot; logic v, il;
        issue(6'h0A, 5'd0, 5'd6, 16'hFFFF, o); model_step(6'h0A, 5'd0, 5'd6, 16'hFFFF, r, v, il, a, ot);
        total++; if (o.result !== 32'd0 || o.zero !== 1'b1) begin bad++;
            $display("FAIL slti: got res=%h zero=%b want 0 1", o.result, o.zero); end
        issue(6'h0B, 5'd0, 5'd6, 16'hFFFF, o); model_step(6'h0B, 5'd0, 5'd6, 16'hFFFF, r, v, il, a, ot);
        total++; if (o.result !== 32'd1 || o.dbg_after !== 32'd1) begin bad++;
            $display("FAIL sltiu: got res=%h reg6=%h want 1 1", o.result, o.dbg_after); end
        issue(6'h09, 5'd3, 5'd0, 16'h0005, o); model_step(6'h09, 5'd3, 5'd0, 16'h0005, r, v, il, a, ot);
        total++; if (o.done !== 1'b1 || o.result !== 32'd8 || o.dbg_after !== 32'd0) begin bad++;
            $display("FAIL r0_write: got done=%b res=%h reg0=%h want 1 8 0", o.done, o.result, o.dbg_after); end
    endtask

    task automatic test_illegal();
        obs_t o;
        issue(6'h23, 5'd3, 5'd9, 16'h1234, o);
        total++; if (o.ill !== 1'b1 || o.result !== 32'h0 || o.done !== 1'b1 || o.ovf !== 1'b0) begin bad++;
            $display("FAIL illegal_flags: got ill=%b res=%h done=%b ovf=%b want 1 0 1 0", o.ill, o.result, o.done, o.ovf); end
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i); #1;
            total++; if (dbg_data !== mregs[i]) begin bad++;
                $display("FAIL illegal_reg%0d: got %h want %h", i, dbg_data, mregs[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0, dones = 0, n = 0;
        logic [31:0] r, a, ot; logic v, il;
        while (!ready && n < 10) begin @(negedge clk); n++; end
        opcode = 6'h09; rs = 5'd9; rt = 5'd9; imm = 16'h0001; dbg_addr = 5'd9; start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (ready && start) accepts++;
            @(posedge clk); @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        repeat (4) model_step(6'h09, 5'd9, 5'd9, 16'h0001, r, v, il, a, ot);
        total++; if (accepts != 4 || dones != 4) begin bad++;
            $display("FAIL b2b_rate: got accepts=%0d dones=%0d want 4 4", accepts, dones); end
        #1;
        total++; if (dbg_data !== mregs[9]) begin bad++;
            $display("FAIL b2b_reg9: got %h want %h", dbg_data, mregs[9]); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [5:0]  ops [11] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h00, 6'h10};
        logic [5:0]  op;
        logic [4:0]  s, t;
        logic [15:0] im;
        logic [31:0] r, a, ot; logic v, il;
        for (int k = 0; k < 40; k++) begin
            op = ops[$urandom_range(0, 10)];
            s = 5'($urandom); t = 5'($urandom); im = 16'($urandom);
            issue(op, s, t, im, o);
            model_step(op, s, t, im, r, v, il, a, ot);
            total++;
            if (o.done !== 1'b1 || o.result !== r || o.ovf !== v || o.ill !== il ||
                o.zero !== (r == 32'h0) || o.datars !== a || o.datart !== ot ||
                o.dbg_wb !== ot || o.dbg_after !== mregs[t] || o.ready_after !== 1'b1) begin
                bad++;
                $display("FAIL rand%0d op=%h rs=%0d rt=%0d imm=%h: got res=%h ovf=%b ill=%b zero=%b rs=%h rt=%h after=%h want res=%h ovf=%b ill=%b rs=%h rt=%h after=%h",
                         k, op, s, t, im, o.result, o.ovf, o.ill, o.zero, o.datars, o.datart, o.dbg_after,
                         r, v, il, a, ot, mregs[t]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        while (!ready && n < 10) begin @(negedge clk); n++; end
        opcode = 6'h08; rs = 5'd3; rt = 5'd7; imm = 16'h000A; start = 1'b1; dbg_addr = 5'd7;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(negedge clk);
        total++; if (done !== 1'b1) begin bad++;
            $display("FAIL rstmid_in_wb: got done=%b want 1", done); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        model_reset();
        total++; if (dbg_data !== 32'd7) begin bad++;
            $display("FAIL rstmid_reg7: got %h want 7", dbg_data); end
        total++; if ({ready, done, overflow, zero, illegal} !== 5'b10000 || {result, datars, datart} !== 96'h0) begin bad++;
            $display("FAIL rstmid_outputs: got ctrl=%b res=%h rs=%h rt=%h want 10000 0 0 0",
                     {ready, done, overflow, zero, illegal}, result, datars, datart); end
    endtask

    task automatic test_reset_start();
        int seen_done = 0;
        @(negedge clk);
        rst = 1'b1; start = 1'b1; opcode = 6'h09; rs = 5'd1; rt = 5'd7; imm = 16'h0005; dbg_addr = 5'd7;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; start = 1'b0;
        model_reset();
        total++; if (ready !== 1'b1) begin bad++;
            $display("FAIL rststart_ready: got %b want 1", ready); end
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            if (done) seen_done++;
        end
        total++; if (seen_done != 0 || dbg_data !== 32'd7) begin bad++;
            $display("FAIL rststart_dropped: got dones=%0d reg7=%h want 0 7", seen_done, dbg_data); end
    endtask

    task automatic test_lui64();
        @(negedge clk);
        total++; if (s64_ready !== 1'b1) begin bad++;
            $display("FAIL w64_ready: got %b want 1", s64_ready); end
        s64_op = 6'h0F; s64_rs = 5'd0; s64_rt = 5'd4; s64_imm = 16'h8001; s64_dbg_addr = 5'd4; s64_start = 1'b1;
        @(posedge clk); @(negedge clk);
        s64_start = 1'b0;
        @(posedge clk); @(negedge clk);
        total++; if (s64_done !== 1'b1 || s64_result !== 64'hFFFFFFFF80010000) begin bad++;
            $display("FAIL w64_lui: got done=%b res=%h want 1 ffffffff80010000", s64_done, s64_result); end
        @(posedge clk); @(negedge clk);
        total++; if (s64_dbg_data !== 64'hFFFFFFFF80010000) begin bad++;
            $display("FAIL w64_lui_reg4: got %h want ffffffff80010000", s64_dbg_data); end
        s64_op = 6'h08; s64_rs = 5'd3; s64_rt = 5'd5; s64_imm = 16'hFFFF; s64_dbg_addr = 5'd5; s64_start = 1'b1;
        @(posedge clk); @(negedge clk);
        s64_start = 1'b0;
        @(posedge clk); @(negedge clk);
        total++; if (s64_result !== 64'd2 || s64_ovf !== 1'b0) begin bad++;
            $display("FAIL w64_addi: got res=%h ovf=%b want 2 0", s64_result, s64_ovf); end
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; opcode = '0; rs = '0; rt = '0; imm = '0; dbg_addr = '0;
        s64_start = 1'b0; s64_op = '0; s64_rs = '0; s64_rt = '0; s64_imm = '0; s64_dbg_addr = '0;
        model_reset();
        test_reset();
        test_addi_basic();
        test_overflow();
        test_logic_lui();
        test_compare();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_reset_start();
        test_lui64();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
